// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and limits for the pushbutton debouncer
package btn_pkg;

  localparam int CNT_W            = 4;
  localparam int STABLE_TICKS_MAX = 15;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    CONF_HI = 2'd1,
    HIGH    = 2'd2,
    CONF_LO = 2'd3
  } btn_state_e;

endpackage

// File: rtl/btn_debounce_tick_if.sv
// rtl/btn_debounce_tick_if.sv - slow-clock/button inputs and debounced outputs
interface btn_debounce_tick_if;

  logic slow_clk;
  logic btn_raw;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic btn_repeat;

  modport master (
    output slow_clk, btn_raw,
    input  btn_level, btn_press, btn_release, btn_repeat
  );

  modport slave (
    input  slow_clk, btn_raw,
    output btn_level, btn_press, btn_release, btn_repeat
  );

endinterface

// File: rtl/btn_debounce_tick_edge_tick.sv
// rtl/btn_debounce_tick_edge_tick.sv - one-flop rising-edge detector for slow data clocks
module edge_tick (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic tick
);

  // Previous value resets high so a level already high at reset never looks like an edge.
  logic din_q;

  // Delay din by one system clock.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) din_q <= 1'b1;
    else          din_q <= din;
  end

  assign tick = din & ~din_q;

endmodule

// File: rtl/btn_debounce_tick.sv
// rtl/btn_debounce_tick.sv - tick-sampled pushbutton debouncer; auto-repeat under BTN_DEBOUNCE_REPEAT_EN
module btn_debounce_tick
  import btn_pkg::*;
#(
  parameter int STABLE_TICKS = 3,
  parameter int REPEAT_DELAY = 6,
  parameter int REPEAT_RATE  = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  btn_debounce_tick_if.slave bus
);

  if (STABLE_TICKS < 1 || STABLE_TICKS > STABLE_TICKS_MAX ||
      REPEAT_DELAY < 1 || REPEAT_DELAY > STABLE_TICKS_MAX ||
      REPEAT_RATE  < 1 || REPEAT_RATE  > STABLE_TICKS_MAX) begin : g_param_check
    $error("btn_debounce_tick: parameter outside 1..15");
  end

  localparam logic [CNT_W-1:0] ST_CNT = CNT_W'(STABLE_TICKS);

  logic             sync_q1;
  logic             btn_s;
  logic             tick;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] stable_cnt, cnt_d, cnt_inc;
  logic             press_d, release_d;
  logic             level_q, press_q, release_q;

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      btn_s   <= 1'b0;
    end else begin
      sync_q1 <= bus.btn_raw;
      btn_s   <= sync_q1;
    end
  end

  edge_tick u_slow_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (bus.slow_clk),
    .tick    (tick)
  );

  assign cnt_inc = stable_cnt + 1'b1;

  // Next state: only tick cycles move the FSM; a contrary sample discards confirm progress.
  always_comb begin
    state_d   = state_q;
    cnt_d     = stable_cnt;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (tick) begin
      unique case (state_q)
        LOW: begin
          if (btn_s) begin
            if (ST_CNT == CNT_W'(1)) begin
              state_d = HIGH;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              state_d = CONF_HI;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CONF_HI: begin
          if (btn_s) begin
            if (cnt_inc == ST_CNT) begin
              state_d = HIGH;
              cnt_d   = '0;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = LOW;
            cnt_d   = '0;
          end
        end
        HIGH: begin
          if (!btn_s) begin
            if (ST_CNT == CNT_W'(1)) begin
              state_d   = LOW;
              cnt_d     = '0;
              release_d = 1'b1;
            end else begin
              state_d = CONF_LO;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CONF_LO: begin
          if (!btn_s) begin
            if (cnt_inc == ST_CNT) begin
              state_d   = LOW;
              cnt_d     = '0;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = HIGH;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  // State, counter and registered outputs; level only moves together with a pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= LOW;
      stable_cnt <= '0;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stable_cnt <= cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      if (press_d)        level_q <= 1'b1;
      else if (release_d) level_q <= 1'b0;
    end
  end

  assign bus.btn_level   = level_q;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_RT  = CNT_W'(REPEAT_RATE);

  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_d, rpt_inc, rpt_tgt;
  logic             rpt_first, rpt_first_d;
  logic             rpt_d, rpt_q;

  assign rpt_inc = rpt_cnt + 1'b1;
  assign rpt_tgt = rpt_first ? RPT_DLY : RPT_RT;

  // Repeat timing: first pulse after the delay, then every rate; restarts on entry to HIGH.
  always_comb begin
    rpt_cnt_d   = rpt_cnt;
    rpt_first_d = rpt_first;
    rpt_d       = 1'b0;
    if (tick) begin
      if ((state_d == HIGH && state_q != HIGH) || state_d == LOW) begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
      end else if (state_q == HIGH || state_q == CONF_LO) begin
        if (rpt_inc == rpt_tgt) begin
          rpt_d       = 1'b1;
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b0;
        end else begin
          rpt_cnt_d = rpt_inc;
        end
      end
    end
  end

  // Repeat counter and registered repeat pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      rpt_q     <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt_d;
      rpt_first <= rpt_first_d;
      rpt_q     <= rpt_d;
    end
  end

  assign bus.btn_repeat = rpt_q;
`else
  assign bus.btn_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce_tick.sv
// tb/tb_btn_debounce_tick.sv - bench for btn_debounce_tick against a tick run-length model
module tb_btn_debounce_tick;

  localparam int ST = 3;
  localparam int RD = 6;
  localparam int RR = 2;
`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int EXP_RPT_HOLD = 4;
`else
  localparam int EXP_RPT_HOLD = 0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  btn_debounce_tick_if bus ();

  btn_debounce_tick #(
    .STABLE_TICKS (ST),
    .REPEAT_DELAY (RD),
    .REPEAT_RATE  (RR)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;

  // Reference: debounced level flips after ST consecutive contrary tick samples.
  logic m_level, m_press, m_release, m_repeat, m_slow_q;
  int   m_run, m_held;
  logic raw_hist[$];
  int   n_press, n_release, n_repeat;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 1'b0; m_press = 1'b0; m_release = 1'b0; m_repeat = 1'b0;
    m_slow_q = 1'b1; m_run = 0; m_held = 0;
    raw_hist.delete();
  endtask

  task automatic model_edge(input logic slow, input logic raw);
    logic s, tk, old_level;
    int   old_run;
    if (!reset_n) begin
      model_reset();
      return;
    end
    s = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 1'b0;
    raw_hist.push_back(raw);
    if (raw_hist.size() > 3) void'(raw_hist.pop_front());
    tk = slow & ~m_slow_q;
    m_slow_q = slow;
    m_press = 1'b0; m_release = 1'b0; m_repeat = 1'b0;
    if (tk) begin
      old_level = m_level;
      old_run   = m_run;
      if (s != m_level) m_run++; else m_run = 0;
      if (m_run == ST) begin
        m_level = s;
        m_run   = 0;
        if (s) m_press = 1'b1; else m_release = 1'b1;
      end
      if (old_level) begin
        if (s && old_run > 0) m_held = 0;
        else if (!m_release) begin
          m_held++;
          if (m_held == RD || (m_held > RD && (m_held - RD) % RR == 0)) m_repeat = 1'b1;
        end
      end
      if (m_press) m_held = 0;
    end
  endtask

  task automatic cyc(input logic slow, input logic raw);
    logic exp_rpt;
    bus.slow_clk = slow;
    bus.btn_raw  = raw;
    @(posedge clock);
    model_edge(slow, raw);
    @(negedge clock);
`ifdef BTN_DEBOUNCE_REPEAT_EN
    exp_rpt = m_repeat;
`else
    exp_rpt = 1'b0;
`endif
    chk("level",   bus.btn_level,   m_level);
    chk("press",   bus.btn_press,   m_press);
    chk("release", bus.btn_release, m_release);
    chk("repeat",  bus.btn_repeat,  exp_rpt);
    n_press   += int'(bus.btn_press);
    n_release += int'(bus.btn_release);
    n_repeat  += int'(bus.btn_repeat);
  endtask

  task automatic period(input logic raw);
    for (int i = 0; i < 8; i++) cyc(1'b0, raw);
    for (int i = 0; i < 8; i++) cyc(1'b1, raw);
  endtask

  task automatic clr_counts();
    n_press = 0; n_release = 0; n_repeat = 0;
  endtask

  task automatic reset_outputs_zero(input string tag);
    chk({tag, "_level"},   bus.btn_level,   1'b0);
    chk({tag, "_press"},   bus.btn_press,   1'b0);
    chk({tag, "_release"}, bus.btn_release, 1'b0);
    chk({tag, "_repeat"},  bus.btn_repeat,  1'b0);
  endtask

  initial begin
    logic sl, rw;
    int   ph;
    bus.slow_clk = 1'b0;
    bus.btn_raw  = 1'b0;
    model_reset();
    clr_counts();

    // reset state
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0);
    reset_outputs_zero("por");
    reset_n = 1'b1;

    // clean press
    clr_counts();
    period(1'b1); period(1'b1);
    chk_int("press_early", n_press, 0);
    period(1'b1); period(1'b1);
    chk_int("clean_press_count", n_press, 1);
    chk("clean_level", bus.btn_level, 1'b1);

    // release
    clr_counts();
    for (int i = 0; i < 4; i++) period(1'b0);
    chk_int("release_count", n_release, 1);
    chk_int("release_no_press", n_press, 0);
    chk("release_level", bus.btn_level, 1'b0);

    // bounce 1,0,1 then hold 1
    clr_counts();
    period(1'b1); period(1'b0); period(1'b1); period(1'b1);
    chk_int("bounce_no_press", n_press, 0);
    period(1'b1); period(1'b1);
    chk_int("bounce_press_count", n_press, 1);
    for (int i = 0; i < 4; i++) period(1'b0);

    // reset in CONF_HI after two ticks
    clr_counts();
    period(1'b1); period(1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
    reset_n = 1'b0;
    model_reset();
    #1;
    reset_outputs_zero("midrst");
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1);
    period(1'b1);
    chk_int("midrst_no_press", n_press, 0);
    period(1'b1);
    chk_int("midrst_press", n_press, 1);
    for (int i = 0; i < 4; i++) period(1'b0);

    // slow_clk stalled high, then low, while the button chatters
    clr_counts();
    for (int i = 0; i < 200; i++) cyc(1'b1, 1'($urandom_range(1, 0)));
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'($urandom_range(1, 0)));
    chk_int("stall_press", n_press, 0);
    chk_int("stall_release", n_release, 0);
    chk("stall_level", bus.btn_level, 1'b0);
    period(1'b0); period(1'b0);

    // hold 12 ticks past the press
    for (int i = 0; i < 3; i++) period(1'b1);
    clr_counts();
    for (int i = 0; i < 12; i++) period(1'b1);
    chk_int("hold_repeat_count", n_repeat, EXP_RPT_HOLD);
    chk_int("hold_no_extra_press", n_press, 0);
    for (int i = 0; i < 4; i++) period(1'b0);

    // random slow_clk half periods and button chatter
    sl = bus.slow_clk;
    rw = bus.btn_raw;
    ph = 0;
    for (int i = 0; i < 1500; i++) begin
      if (ph == 0) begin
        sl = ~sl;
        ph = $urandom_range(12, 2);
      end
      ph--;
      if ($urandom_range(11, 0) == 0) rw = ~rw;
      cyc(sl, rw);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
